// File: rtl/isqrt_pkg.sv
// Shared types and widths for the round-robin integer square-root scheduler.
package isqrt_pkg;

  localparam int OP_W  = 15;
  localparam int RES_W = (OP_W + 1) / 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/isqrt_iter_core.sv
// Iterative square-root datapath: walks R upward until (R+1)^2 exceeds D.
// finish is combinational in the last search cycle; root holds R at that point.
module isqrt_iter_core
  import isqrt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  operand,
  output logic             finish,
  output logic [RES_W-1:0] root
);

  logic [OP_W-1:0]  d_q, d_d;
  logic [RES_W-1:0] r_q, r_d;
  logic             active_q, active_d;
  logic [15:0]      r_inc;
  logic [15:0]      sq;

  // Square the next root candidate and compare against the operand.
  always_comb begin
    r_inc  = {{(16-RES_W){1'b0}}, r_q} + 16'd1;
    sq     = r_inc * r_inc;
    finish = active_q && (sq > {{(16-OP_W){1'b0}}, d_q});
    root   = r_q;
  end

  // Load on start, otherwise advance R until the compare fires.
  always_comb begin
    d_d      = d_q;
    r_d      = r_q;
    active_d = active_q;
    if (start) begin
      d_d      = operand;
      r_d      = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (finish) begin
        active_d = 1'b0;
      end else begin
        r_d = r_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q      <= '0;
      r_q      <= '0;
      active_q <= 1'b0;
    end else begin
      d_q      <= d_d;
      r_q      <= r_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/isqrt_rr_scheduler.sv
// Round-robin front end sharing one isqrt_iter_core between two requesters.
//
// state | meaning
// IDLE  | waiting for a request; may grant in the same cycle a done is shown
// RUN   | core searching for the root of the granted operand
module isqrt_rr_scheduler
  import isqrt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [OP_W-1:0]  opa,
  input  logic [OP_W-1:0]  opb,
  output logic [1:0]       ack,
  output logic [1:0]       done,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic             owner
);

  state_e           state_q, state_d;
  req_id_t          ptr_q, ptr_d;
  req_id_t          owner_q, owner_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic [RES_W-1:0] result_q, result_d;

  req_id_t          gnt_id;
  logic             core_start;
  logic             core_finish;
  logic [RES_W-1:0] core_root;
  logic [OP_W-1:0]  core_operand;

  isqrt_iter_core u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (core_start),
    .operand (core_operand),
    .finish  (core_finish),
    .root    (core_root)
  );

  // Arbitration, next-state and handshake pulse generation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    ack_d      = 2'b00;
    done_d     = 2'b00;
    result_d   = result_q;
    core_start = 1'b0;
    // The pointer only matters when both ask; a lone requester always wins.
    gnt_id       = (req == 2'b11) ? ptr_q : req[1];
    core_operand = gnt_id ? opb : opa;
    case (state_q)
      IDLE: begin
        if (|req) begin
          core_start    = 1'b1;
          owner_d       = gnt_id;
          ptr_d         = ~gnt_id;
          ack_d[gnt_id] = 1'b1;
          state_d       = RUN;
        end
      end
      RUN: begin
        if (core_finish) begin
          result_d       = core_root;
          done_d[owner_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign ack    = ack_q;
  assign done   = done_q;
  assign result = result_q;
  assign owner  = owner_q;
  assign busy   = (state_q == RUN);

endmodule
